// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module unified_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, MISAL} state_t;

    state_t             state, state_nxt;
    logic               owner;       // 1 = LS, 0 = IF
    logic               last_owner;
    logic [CNT_W-1:0]   wait_cnt;
    logic [1:0]         ls_size_eff;
    logic               ls_misal;
    logic               timeout;

    assign ls_size_eff = (ls_size == 2'b00) ? 2'b01 : ls_size;
    assign ls_misal    = (ls_size_eff == 2'b01 && ls_addr[1:0] != 2'b00) ||
                         (ls_size_eff == 2'b10 && ls_addr[0]);
    // Abort on the MAX_WAIT-th consecutive cycle without mem_ready.
    assign timeout     = !mem_ready && (wait_cnt == CNT_W'(MAX_WAIT - 1));
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        case (state)
            IDLE: begin
                if (if_req && (!ls_req || last_owner)) begin
                    if_gnt    = 1'b1;
                    state_nxt = BUSY;
                end else if (ls_req) begin
                    ls_gnt    = 1'b1;
                    state_nxt = ls_misal ? MISAL : BUSY;
                end
            end
            BUSY:    if (mem_ready || timeout) state_nxt = IDLE;
            MISAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_size   <= 2'b00;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            ls_rvalid  <= 1'b0;
            ls_rdata   <= '0;
            ls_err     <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            ls_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_gnt) begin
                        owner      <= 1'b0;
                        last_owner <= 1'b0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_size   <= 2'b01;
                        mem_addr   <= if_addr;
                    end else if (ls_gnt) begin
                        owner      <= 1'b1;
                        last_owner <= 1'b1;
                        if (!ls_misal) begin
                            mem_req   <= 1'b1;
                            mem_we    <= ls_we;
                            mem_size  <= ls_size_eff;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready || timeout) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wait_cnt <= '0;
                        // Stores and aborts return zero data.
                        if (owner) begin
                            ls_rvalid <= 1'b1;
                            ls_err    <= !mem_ready;
                            ls_rdata  <= (mem_ready && !mem_we) ? mem_rdata : '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_err    <= !mem_ready;
                            if_rdata  <= mem_ready ? mem_rdata : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MISAL: begin
                    ls_rvalid <= 1'b1;
                    ls_err    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [1:0]  ls_size = 2'b01;
    logic [31:0] ls_addr = '0, ls_wdata = '0;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we, mem_ready = 1'b0;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit ls; logic [31:0] rdata; bit err; } rsp_t;
    typedef struct { logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; } req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int mem_wait = 0;
    logic [31:0] rd_val = '0;

    assign mem_rdata = rd_val;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(bit ls, bit issued, logic we, logic [1:0] size,
                              logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, bit err);
        rsp_t r;
        req_t q;
        r.ls = ls; r.rdata = rdata; r.err = err;
        rsp_q.push_back(r);
        if (issued) begin
            q.we = we; q.size = size; q.addr = addr; q.wdata = wdata;
            req_q.push_back(q);
        end
    endtask

    // Called just after a negedge; returns at negedge+1 of the grant cycle.
    task automatic wait_gnt(output bit is_ls, output int waited);
        is_ls  = 1'b0;
        waited = -1;
        for (int t = 0; t < 12; t++) begin
            #1;
            if (if_gnt || ls_gnt) begin
                check("gnt_onehot", {63'd0, if_gnt & ls_gnt}, 64'd0);
                is_ls  = ls_gnt;
                waited = t;
                return;
            end
            @(negedge clk);
        end
        check("gnt_timeout", 64'd0, 64'd1);
    endtask

    // Memory model: mem_ready rises after mem_wait cycles of a held request.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                mem_ready = (cnt >= mem_wait);
                cnt++;
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Response and memory-request monitor.
    initial begin
        rsp_t r;
        req_t q;
        logic prev_req;
        logic [31:0] prev_addr, prev_wdata;
        logic [1:0]  prev_size;
        logic        prev_we;
        prev_req = 1'b0;
        prev_addr = '0; prev_wdata = '0; prev_size = '0; prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (if_rvalid || ls_rvalid) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        r = rsp_q.pop_front();
                        check("rsp_owner", {63'd0, ls_rvalid}, {63'd0, r.ls});
                        check("rsp_rdata", r.ls ? ls_rdata : if_rdata, r.rdata);
                        check("rsp_err", {63'd0, r.ls ? ls_err : if_err}, {63'd0, r.err});
                    end
                end
                if (mem_req && !prev_req) begin
                    if (req_q.size() == 0) begin
                        check("mem_unexpected", 64'd1, 64'd0);
                    end else begin
                        q = req_q.pop_front();
                        check("mem_we", {63'd0, mem_we}, {63'd0, q.we});
                        check("mem_size", {62'd0, mem_size}, {62'd0, q.size});
                        check("mem_addr", mem_addr, q.addr);
                        if (q.we) check("mem_wdata", mem_wdata, q.wdata);
                    end
                end else if (mem_req && prev_req) begin
                    check("mem_stable", {mem_we, mem_size, mem_addr, mem_wdata},
                          {prev_we, prev_size, prev_addr, prev_wdata});
                end else if (!mem_req) begin
                    check("mem_we_idle", {63'd0, mem_we}, 64'd0);
                end
            end
            prev_req = mem_req; prev_we = mem_we; prev_size = mem_size;
            prev_addr = mem_addr; prev_wdata = mem_wdata;
        end
    end

    initial begin
        bit g;
        int w;
        int n;
        bit exp_ls;

        repeat (2) @(negedge clk);
        check("rst_outputs", {mem_req, mem_we, busy, if_gnt, ls_gnt, if_rvalid, ls_rvalid,
                              if_err, ls_err}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        reset = 1'b0;

        // IF-only fetch, zero-wait memory.
        @(negedge clk);
        mem_wait = 0; rd_val = 32'h0050_0093;
        if_addr = 32'h40; if_req = 1'b1;
        wait_gnt(g, w);
        check("t1_gnt_if", {63'd0, g}, 64'd0);
        check("t1_gnt_now", w, 0);
        expect_txn(0, 1, 1'b0, 2'b01, 32'h40, 32'h0, 32'h0050_0093, 0);
        @(negedge clk);
        if_req = 1'b0;
        check("t1_mem_req", {63'd0, mem_req}, 64'd1);
        check("t1_mem_addr", mem_addr, 64'h40);
        @(negedge clk);
        check("t1_rvalid", {63'd0, if_rvalid}, 64'd1);
        repeat (2) @(negedge clk);

        // Both requesting after reset: strict alternation starting with IF.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd_val = 32'h1122_3344;
        if_addr = 32'h80; if_req = 1'b1;
        ls_we = 1'b0; ls_size = 2'b01; ls_addr = 32'h2000; ls_req = 1'b1;
        exp_ls = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g, w);
            check("t2_order", {63'd0, g}, {63'd0, exp_ls});
            if (i > 0) check("t2_spacing", w, 1);
            if (g) expect_txn(1, 1, 1'b0, 2'b01, 32'h2000, 32'h0, 32'h1122_3344, 0);
            else   expect_txn(0, 1, 1'b0, 2'b01, 32'h80, 32'h0, 32'h1122_3344, 0);
            exp_ls = !exp_ls;
            @(negedge clk);
            if (i == 3) begin if_req = 1'b0; ls_req = 1'b0; end
        end
        repeat (3) @(negedge clk);

        // Byte store with three wait cycles.
        mem_wait = 3;
        ls_we = 1'b1; ls_size = 2'b11; ls_addr = 32'h1003; ls_wdata = 32'hAB; ls_req = 1'b1;
        wait_gnt(g, w);
        check("t3_gnt_ls", {63'd0, g}, 64'd1);
        expect_txn(1, 1, 1'b1, 2'b11, 32'h1003, 32'hAB, 32'h0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ls_req = 1'b0;
            check("t3_mem_held", {63'd0, mem_req}, 64'd1);
        end
        @(negedge clk);
        check("t3_rvalid", {mem_req, ls_rvalid}, 64'd1);
        mem_wait = 0;
        repeat (2) @(negedge clk);

        // Misaligned word load, then aligned-enough half load at the same address.
        ls_we = 1'b0; ls_size = 2'b01; ls_addr = 32'h1002; ls_req = 1'b1;
        wait_gnt(g, w);
        check("t4_gnt_ls", {63'd0, g}, 64'd1);
        expect_txn(1, 0, 1'b0, 2'b01, 32'h1002, 32'h0, 32'h0, 1);
        @(negedge clk);
        ls_req = 1'b0;
        check("t4_no_mem", {mem_req, busy}, 64'd1);
        @(negedge clk);
        check("t4_rvalid", {mem_req, ls_rvalid}, 64'd1);
        rd_val = 32'h0000_BEEF;
        ls_size = 2'b10; ls_req = 1'b1;
        wait_gnt(g, w);
        expect_txn(1, 1, 1'b0, 2'b10, 32'h1002, 32'h0, 32'h0000_BEEF, 0);
        @(negedge clk);
        ls_req = 1'b0;
        check("t4_half_issued", {63'd0, mem_req}, 64'd1);
        repeat (3) @(negedge clk);

        // Fetch timeout after MAX_WAIT cycles, then immediate LS grant.
        mem_wait = 1000;
        if_addr = 32'h44; if_req = 1'b1;
        wait_gnt(g, w);
        check("t5_gnt_if", {63'd0, g}, 64'd0);
        expect_txn(0, 1, 1'b0, 2'b01, 32'h44, 32'h0, 32'h0, 1);
        @(negedge clk);
        if_req = 1'b0;
        n = 0;
        for (int t = 0; t < 40; t++) begin
            if (!mem_req) break;
            n++;
            @(negedge clk);
        end
        check("t5_wait_cycles", n, 15);
        check("t5_abort", {if_rvalid, if_err, busy}, 64'b110);
        mem_wait = 0; rd_val = 32'hCAFE_F00D;
        ls_we = 1'b0; ls_size = 2'b01; ls_addr = 32'h3000; ls_req = 1'b1;
        wait_gnt(g, w);
        check("t5_next_gnt", {g, 31'd0, w[31:0]}, {1'b1, 63'd0});
        expect_txn(1, 1, 1'b0, 2'b01, 32'h3000, 32'h0, 32'hCAFE_F00D, 0);
        @(negedge clk);
        ls_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a BUSY transaction.
        mem_wait = 1000;
        if_addr = 32'h50; if_req = 1'b1;
        wait_gnt(g, w);
        begin
            req_t q;
            q.we = 1'b0; q.size = 2'b01; q.addr = 32'h50; q.wdata = '0;
            req_q.push_back(q);
        end
        @(negedge clk);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("t6_async_drop", {mem_req, busy}, 64'd0);
        if_addr = 32'h60; if_req = 1'b1;
        ls_we = 1'b1; ls_size = 2'b01; ls_addr = 32'h2004; ls_wdata = 32'h55AA_55AA; ls_req = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_no_rvalid", {if_rvalid, ls_rvalid}, 64'd0);
        reset = 1'b0; mem_wait = 0; rd_val = 32'h0BAD_F00D;
        wait_gnt(g, w);
        check("t6_if_first", {g, 31'd0, w[31:0]}, 64'd0);
        expect_txn(0, 1, 1'b0, 2'b01, 32'h60, 32'h0, 32'h0BAD_F00D, 0);
        @(negedge clk);
        wait_gnt(g, w);
        check("t6_ls_second", {63'd0, g}, 64'd1);
        expect_txn(1, 1, 1'b1, 2'b01, 32'h2004, 32'h55AA_55AA, 32'h0, 0);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        repeat (4) @(negedge clk);

        check("drain_rsp", rsp_q.size(), 0);
        check("drain_req", req_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
